// File: rtl/cursor_pair_ctrl_pkg.sv
// Shared definitions for the cursor pair controller: row defaults, step FSM
// encoding and small helpers. Optional auto-repeat is enabled by CURSOR_REPEAT_EN.
package cursor_pair_ctrl_pkg;

  localparam logic [10:0] DEF_POS_MIN   = 11'd12;
  localparam logic [10:0] DEF_POS_MAX   = 11'd756;
  localparam logic [10:0] DEF_STEP      = 11'd12;
  localparam logic [10:0] DEF_A_DEFAULT = 11'd264;
  localparam logic [10:0] DEF_B_DEFAULT = 11'd504;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } step_state_e;

  // dir = {up, down}; only a single pressed button is a usable direction
  function automatic logic dir_valid(input logic [1:0] dir);
    return dir[1] ^ dir[0];
  endfunction

  function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/cursor_pair_ctrl_step_repeat_gen.sv
// Press/hold/repeat sequencer producing one-cycle step pulses from the button pair.
// Counter and REPEAT behaviour exist only when CURSOR_REPEAT_EN is defined.
module cursor_pair_ctrl_step_repeat_gen
  import cursor_pair_ctrl_pkg::*;
`ifdef CURSOR_REPEAT_EN
#(
  parameter int unsigned HOLD_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned CNT_W         = 26
)
`endif
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       up_i,
  input  logic       down_i,
  output logic       step_up_o,
  output logic       step_down_o,
  output logic [1:0] state_o
);

  logic [1:0]  dir;
  logic [1:0]  dir_q, dir_d;
  step_state_e state_q, state_d;

`ifdef CURSOR_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign dir     = {up_i, down_i};
  assign state_o = state_q;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    step_up_o   = 1'b0;
    step_down_o = 1'b0;
`ifdef CURSOR_REPEAT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (dir_valid(dir)) begin
          step_up_o   = dir[1];
          step_down_o = dir[0];
          dir_d       = dir;
          state_d     = ST_HOLD;
`ifdef CURSOR_REPEAT_EN
          cnt_d       = '0;
`endif
        end
      end
      ST_HOLD: begin
        // Any change of the pair (release, both, reversal) ends the press
        if (dir != dir_q) begin
          state_d = ST_IDLE;
        end
`ifdef CURSOR_REPEAT_EN
        else if (cnt_q == HOLD_LAST) begin
          step_up_o   = dir_q[1];
          step_down_o = dir_q[0];
          cnt_d       = '0;
          state_d     = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
      ST_REPEAT: begin
`ifdef CURSOR_REPEAT_EN
        if (dir != dir_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == REP_LAST) begin
          step_up_o   = dir_q[1];
          step_down_o = dir_q[0];
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      dir_q   <= 2'b00;
`ifdef CURSOR_REPEAT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
`ifdef CURSOR_REPEAT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: rtl/cursor_pair_ctrl.sv
// Two horizontal measurement cursors sharing one up/down/select button set.
// Hold-to-repeat stepping is built only when CURSOR_REPEAT_EN is defined.
module cursor_pair_ctrl
  import cursor_pair_ctrl_pkg::*;
#(
  parameter logic [10:0] POS_MIN   = DEF_POS_MIN,
  parameter logic [10:0] POS_MAX   = DEF_POS_MAX,
  parameter logic [10:0] STEP      = DEF_STEP,
  parameter logic [10:0] A_DEFAULT = DEF_A_DEFAULT,
  parameter logic [10:0] B_DEFAULT = DEF_B_DEFAULT
`ifdef CURSOR_REPEAT_EN
  ,
  parameter int unsigned HOLD_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned CNT_W         = 26
`endif
) (
  input  logic        clk_fpga,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_sel,
  input  logic [10:0] vc_visible,
  output logic        active_sel,
  output logic [10:0] cursor_a_pos,
  output logic [10:0] cursor_b_pos,
  output logic [10:0] cursor_delta,
  output logic        in_cursor_a,
  output logic        in_cursor_b
);

  logic        step_up, step_down;
  logic [1:0]  rep_state;
  logic        busy;
  logic        sel_q;
  logic        active_q, active_d;
  logic [10:0] a_q, a_d, b_q, b_d;
  logic [10:0] delta_q;
  logic [10:0] act_row, next_row;

  cursor_pair_ctrl_step_repeat_gen
`ifdef CURSOR_REPEAT_EN
  #(
    .HOLD_DELAY    (HOLD_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD),
    .CNT_W         (CNT_W)
  )
`endif
  u_step (
    .clk_i       (clk_fpga),
    .rst_i       (rst),
    .up_i        (btn_up),
    .down_i      (btn_down),
    .step_up_o   (step_up),
    .step_down_o (step_down),
    .state_o     (rep_state)
  );

  assign busy    = (rep_state != 2'(ST_IDLE));
  assign act_row = active_q ? b_q : a_q;

  always_comb begin
    next_row = act_row;
    // Clamp at the screen limits by refusing the step; sequencing continues
    if (step_up && (act_row != POS_MIN)) begin
      next_row = act_row - STEP;
    end else if (step_down && (act_row != POS_MAX)) begin
      next_row = act_row + STEP;
    end
    a_d = a_q;
    b_d = b_q;
    if (active_q) b_d = next_row;
    else          a_d = next_row;
    // Select edges are only honoured between presses; they are not queued
    active_d = active_q ^ (btn_sel & ~sel_q & ~busy);
  end

  always_ff @(posedge clk_fpga or posedge rst) begin
    if (rst) begin
      sel_q    <= 1'b0;
      active_q <= 1'b0;
      a_q      <= A_DEFAULT;
      b_q      <= B_DEFAULT;
      delta_q  <= B_DEFAULT - A_DEFAULT;
    end else begin
      sel_q    <= btn_sel;
      active_q <= active_d;
      a_q      <= a_d;
      b_q      <= b_d;
      delta_q  <= abs_diff(a_q, b_q);
    end
  end

  assign active_sel   = active_q;
  assign cursor_a_pos = a_q;
  assign cursor_b_pos = b_q;
  assign cursor_delta = delta_q;
  assign in_cursor_a  = (vc_visible == a_q);
  assign in_cursor_b  = (vc_visible == b_q);

endmodule
